systolic_tile_feeder: RTL and testbench

Upstream sequencer and address generator for the 8x8 systolic array. On each `start` it:
- loads the weight word into the array and clears its accumulators;
- reads the 12 input-tile rows from image memory and streams them into `I_stream_in`, with zero-padding outside the image;
- waits out the array's drain latency, then pulses `done` so the downstream stage can sample `Psum_out_stream`.

---
 rtl/systolic_tile_feeder_if.sv | 49 ++++
 rtl/systolic_tile_feeder.sv | 174 +++++++++++++++++
 tb/tb_systolic_tile_feeder.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_tile_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : systolic_tile_feeder_if
// Description : Bundles the tile request, image-memory read port and
//               systolic-array drive signals of the tile feeder.
//               slave  : feeder side (consumes the request and read data,
//                        drives the memory strobe/address and the array).
//               master : environment side (the mirror of slave).
//   start, origin_row, origin_col, w_in   : tile request
//   img_rd_en, img_addr, img_rd_data      : image memory read port
//   load_W, W_load_in, reset_psum,
//   enable_cycle, I_stream_in,
//   load_psum_from_mem                    : systolic array control/data
//   busy, done                            : pass status
// Revision    : 1.0 - initial release
// ============================================================================
interface systolic_tile_feeder_if #(
  parameter int ARRAY_SIZE = 8,
  parameter int ADDR_W     = 12
);
  logic                    start;
  logic [5:0]              origin_row;
  logic [5:0]              origin_col;
  logic [8*ARRAY_SIZE-1:0] w_in;
  logic                    img_rd_en;
  logic [ADDR_W-1:0]       img_addr;
  logic [8*ARRAY_SIZE-1:0] img_rd_data;
  logic                    load_W;
  logic [8*ARRAY_SIZE-1:0] W_load_in;
  logic                    reset_psum;
  logic                    enable_cycle;
  logic [8*ARRAY_SIZE-1:0] I_stream_in;
  logic                    load_psum_from_mem;
  logic                    busy;
  logic                    done;

  modport slave (
    input  start, origin_row, origin_col, w_in, img_rd_data,
    output img_rd_en, img_addr, load_W, W_load_in, reset_psum,
           enable_cycle, I_stream_in, load_psum_from_mem, busy, done
  );

  modport master (
    output start, origin_row, origin_col, w_in, img_rd_data,
    input  img_rd_en, img_addr, load_W, W_load_in, reset_psum,
           enable_cycle, I_stream_in, load_psum_from_mem, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/systolic_tile_feeder.sv
`default_nettype none
// ============================================================================
// Module      : systolic_tile_feeder
// Description : Sequencer and address generator feeding one input tile into
//               the systolic array. Per accepted start: pulse load_W, pulse
//               reset_psum, stream STREAM_CYCLES image rows (zero-padded
//               outside the image), wait out the array drain latency and
//               pulse done.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : systolic_tile_feeder_if.slave (request, memory port, array drive)
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_tile_feeder #(
  parameter int ARRAY_SIZE   = 8,
  parameter int KERNEL_SIZE  = 5,
  parameter int IMG_W        = 64,
  parameter int IMG_H        = 64,
  parameter int ADDR_W       = 12,
  parameter int DRAIN_CYCLES = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  systolic_tile_feeder_if.slave bus
);

  localparam int STREAM_CYCLES = ARRAY_SIZE + KERNEL_SIZE - 1;
  localparam int DATA_W        = 8 * ARRAY_SIZE;
  localparam int IDX_W         = $clog2(STREAM_CYCLES);
  localparam int DRAIN_W       = $clog2(DRAIN_CYCLES + 1);
  // One spare bit on top of the 6-bit origin so row/column sums never wrap.
  localparam int ROW_W         = 6 + IDX_W + 1;
  localparam int COL_W         = 6 + $clog2(ARRAY_SIZE) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOADW  = 3'd1,
    S_CLR    = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DRAIN_W-1:0]      drain_q, drain_d;
  logic [5:0]              origin_row_q, origin_row_d;
  logic [5:0]              origin_col_q, origin_col_d;
  logic [DATA_W-1:0]       w_q, w_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    pad_q, pad_d;
  logic [ARRAY_SIZE-1:0]   col_mask_q, col_mask_d;

  logic [ROW_W-1:0]        w_row;
  logic                    w_row_in_img;
  logic [ARRAY_SIZE-1:0]   w_col_oob;
  logic                    w_rd_en;

  assign w_row        = ROW_W'(origin_row_q) + ROW_W'(idx_q);
  assign w_row_in_img = (w_row < ROW_W'(IMG_H));

  // Lanes whose pixel column falls beyond the right image edge.
  generate
    for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_col_mask
      assign w_col_oob[c] = (COL_W'(origin_col_q) + COL_W'(c)) >= COL_W'(IMG_W);
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    drain_d      = drain_q;
    origin_row_d = origin_row_q;
    origin_col_d = origin_col_q;
    w_d          = w_q;
    addr_d       = addr_q;
    resp_valid_d = 1'b0;
    pad_d        = pad_q;
    col_mask_d   = col_mask_q;
    w_rd_en      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          origin_row_d = bus.origin_row;
          origin_col_d = bus.origin_col;
          w_d          = bus.w_in;
          idx_d        = '0;
          drain_d      = '0;
          state_d      = S_LOADW;
        end
      end
      S_LOADW: state_d = S_CLR;
      S_CLR:   state_d = S_STREAM;
      S_STREAM: begin
        // Padding flag and column mask travel one cycle with the read so
        // they line up with the data the memory returns.
        resp_valid_d = 1'b1;
        pad_d        = ~w_row_in_img;
        col_mask_d   = w_col_oob;
        if (w_row_in_img) begin
          w_rd_en = 1'b1;
          addr_d  = ADDR_W'(w_row) * ADDR_W'(IMG_W) + ADDR_W'(origin_col_q);
        end
        if (idx_q == IDX_W'(STREAM_CYCLES - 1)) begin
          idx_d   = '0;
          drain_d = '0;
          state_d = S_DRAIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DRAIN: begin
        // The first DRAIN cycle carries the last stream response, so the
        // state lasts DRAIN_CYCLES+1 cycles.
        if (drain_q == DRAIN_W'(DRAIN_CYCLES)) begin
          drain_d = '0;
          state_d = S_DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      drain_q      <= '0;
      origin_row_q <= '0;
      origin_col_q <= '0;
      w_q          <= '0;
      addr_q       <= '0;
      resp_valid_q <= 1'b0;
      pad_q        <= 1'b0;
      col_mask_q   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      drain_q      <= drain_d;
      origin_row_q <= origin_row_d;
      origin_col_q <= origin_col_d;
      w_q          <= w_d;
      addr_q       <= addr_d;
      resp_valid_q <= resp_valid_d;
      pad_q        <= pad_d;
      col_mask_q   <= col_mask_d;
    end
  end

  // Address follows the fresh computation while reading, otherwise holds.
  assign bus.img_rd_en          = w_rd_en;
  assign bus.img_addr           = addr_d;
  assign bus.load_W             = (state_q == S_LOADW);
  assign bus.reset_psum         = (state_q == S_CLR);
  assign bus.done               = (state_q == S_DONE);
  assign bus.busy               = (state_q != S_IDLE);
  assign bus.W_load_in          = w_q;
  assign bus.enable_cycle       = resp_valid_q;
  assign bus.load_psum_from_mem = 1'b0;

  generate
    for (genvar c = 0; c < ARRAY_SIZE; c++) begin : g_lane
      assign bus.I_stream_in[8*c +: 8] =
        (resp_valid_q && !pad_q && !col_mask_q[c]) ? bus.img_rd_data[8*c +: 8] : 8'd0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_systolic_tile_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_tile_feeder
// Description : Self-checking bench for systolic_tile_feeder. An image memory
//               model answers reads; every pass is checked cycle by cycle
//               against a reference built from the pass timeline and the
//               padding rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_tile_feeder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_tile_feeder_if #(.ARRAY_SIZE(8), .ADDR_W(12)) bus ();

  systolic_tile_feeder #(
    .ARRAY_SIZE(8), .KERNEL_SIZE(5), .IMG_W(64), .IMG_H(64),
    .ADDR_W(12), .DRAIN_CYCLES(20)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [0:4103];
  bit         lane_mode = 1'b0;

  // Image memory: 8 consecutive bytes, one cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.img_rd_en) begin
      for (int c = 0; c < 8; c++)
        bus.img_rd_data[8*c +: 8] <= lane_mode ? 8'(c) : mem[int'(bus.img_addr) + c];
    end
  end

  function automatic logic [7:0] exp_lane(input int r, input int c0, input int c);
    if (r >= 64 || c0 + c >= 64) return 8'd0;
    if (lane_mode) return 8'(c);
    return mem[r*64 + c0 + c];
  endfunction

  // Checks one full pass; called just after the edge that accepted start.
  task automatic monitor_pass(input int r0, input int c0, input logic [63:0] w);
    int          last_addr;
    int          t;
    logic [5:0]  exp_ctrl, got_ctrl;
    logic [63:0] exp_s;
    bit          stream, en;
    last_addr = 0;
    for (int n = 0; n <= 35; n++) begin
      @(negedge clk);
      t      = n - 2;
      stream = (n >= 2 && n <= 13);
      en     = (n >= 3 && n <= 14);
      exp_ctrl = {n == 0, n == 1, en, n == 35, 1'b1, stream && (r0 + t < 64)};
      got_ctrl = {bus.load_W, bus.reset_psum, bus.enable_cycle, bus.done, bus.busy, bus.img_rd_en};
      n_cmp++;
      if (got_ctrl !== exp_ctrl) begin
        n_err++;
        $display("FAIL ctrl n=%0d {ldW,clr,en,done,busy,rd}: got %b want %b", n, got_ctrl, exp_ctrl);
      end
      if (stream) begin
        if (r0 + t < 64) last_addr = (r0 + t) * 64 + c0;
        n_cmp++;
        if (bus.img_addr !== 12'(last_addr)) begin
          n_err++;
          $display("FAIL img_addr n=%0d: got %0d want %0d", n, bus.img_addr, last_addr);
        end
      end
      for (int c = 0; c < 8; c++)
        exp_s[8*c +: 8] = en ? exp_lane(r0 + n - 3, c0, c) : 8'd0;
      n_cmp++;
      if (bus.I_stream_in !== exp_s) begin
        n_err++;
        $display("FAIL I_stream_in n=%0d: got %h want %h", n, bus.I_stream_in, exp_s);
      end
      n_cmp++;
      if ({bus.W_load_in, bus.load_psum_from_mem} !== {w, 1'b0}) begin
        n_err++;
        $display("FAIL W_load_in n=%0d: got %h/%b want %h/0", n, bus.W_load_in, bus.load_psum_from_mem, w);
      end
    end
  endtask

  task automatic launch(input int r0, input int c0, input logic [63:0] w);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.origin_row = 6'(r0);
    bus.origin_col = 6'(c0);
    bus.w_in       = w;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.img_rd_en, bus.load_W, bus.enable_cycle} !== 4'b0000) begin
      n_err++;
      $display("FAIL %s idle: got busy/rd/ldW/en=%b want 0000", tag,
               {bus.busy, bus.img_rd_en, bus.load_W, bus.enable_cycle});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if ({bus.load_W, bus.reset_psum, bus.enable_cycle, bus.done, bus.busy, bus.img_rd_en,
         bus.load_psum_from_mem, bus.W_load_in, bus.img_addr, bus.I_stream_in} !== '0) begin
      n_err++;
      $display("FAIL reset outputs: got nonzero (addr=%0d W=%h I=%h) want 0",
               bus.img_addr, bus.W_load_in, bus.I_stream_in);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle_check("after_reset");
  endtask

  task automatic test_full_tile();
    for (int i = 0; i < 4104; i++) mem[i] = 8'h02;
    launch(0, 0, {8{8'h01}});
    monitor_pass(0, 0, {8{8'h01}});
    idle_check("full_tile_end");
  endtask

  task automatic test_col_edge();
    for (int i = 0; i < 4104; i++) mem[i] = 8'(i);
    launch(10, 60, 64'h1122334455667788);
    monitor_pass(10, 60, 64'h1122334455667788);
  endtask

  task automatic test_row_edge();
    for (int i = 0; i < 4104; i++) mem[i] = 8'($urandom);
    launch(56, 0, 64'hA5A5_0F0F_5A5A_F0F0);
    monitor_pass(56, 0, 64'hA5A5_0F0F_5A5A_F0F0);
  endtask

  // start stays high throughout; mid-pass origin/weight changes must be ignored.
  task automatic test_back_to_back();
    logic [63:0] wa, wb;
    wa = {$urandom, $urandom};
    wb = {$urandom, $urandom};
    @(negedge clk);
    bus.start = 1'b1; bus.origin_row = 6'd5; bus.origin_col = 6'd9; bus.w_in = wa;
    @(posedge clk);
    #1;
    bus.origin_row = 6'd33; bus.origin_col = 6'd17; bus.w_in = wb;
    monitor_pass(5, 9, wa);
    @(negedge clk);
    n_cmp++;
    if ({bus.busy, bus.load_W, bus.done} !== 3'b000) begin
      n_err++;
      $display("FAIL b2b gap n=36 busy/ldW/done: got %b want 000", {bus.busy, bus.load_W, bus.done});
    end
    @(posedge clk);
    #1 bus.start = 1'b0;
    monitor_pass(33, 17, wb);
    idle_check("b2b_end");
  endtask

  task automatic test_reset_mid_pass();
    launch(20, 30, 64'hDEADBEEF_CAFEF00D);
    for (int n = 0; n <= 7; n++) @(negedge clk);
    n_cmp++;
    if (bus.img_addr !== 12'(25*64 + 30)) begin
      n_err++;
      $display("FAIL pre_reset addr: got %0d want %0d", bus.img_addr, 25*64 + 30);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.load_W, bus.reset_psum, bus.enable_cycle, bus.done, bus.busy, bus.img_rd_en,
         bus.W_load_in, bus.img_addr, bus.I_stream_in} !== '0) begin
      n_err++;
      $display("FAIL async_reset outputs: got rd=%b busy=%b addr=%0d W=%h want all 0",
               bus.img_rd_en, bus.busy, bus.img_addr, bus.W_load_in);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle_check("post_reset");
    launch(41, 7, 64'h0123456789ABCDEF);
    monitor_pass(41, 7, 64'h0123456789ABCDEF);
  endtask

  task automatic test_lane_map();
    lane_mode = 1'b1;
    launch(3, 58, 64'h0);
    monitor_pass(3, 58, 64'h0);
    lane_mode = 1'b0;
  endtask

  task automatic test_random();
    int r0, c0;
    logic [63:0] w;
    for (int i = 0; i < 4104; i++) mem[i] = 8'($urandom);
    for (int p = 0; p < 4; p++) begin
      r0 = $urandom_range(63);
      c0 = $urandom_range(63);
      w  = {$urandom, $urandom};
      launch(r0, c0, w);
      monitor_pass(r0, c0, w);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.start = 1'b0; bus.origin_row = '0; bus.origin_col = '0; bus.w_in = '0;
    bus.img_rd_data = '0;
    test_reset();
    test_full_tile();
    test_col_edge();
    test_row_edge();
    test_back_to_back();
    test_reset_mid_pass();
    test_lane_map();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
